mastermind_game: RTL and testbench



---
 rtl/mastermind_game.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_mastermind_game.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_game.sv
// Two-player Mastermind controller: secret code entry, guess rounds with LED feedback, match scoring.
// Optional MASTERMIND_REVEAL_CODE_EN: at round end, show the secret code when the codemaker won.
module mastermind_game #(
    parameter int unsigned SHOW_CYCLES = 4,
    parameter int unsigned WIN_SCORE   = 2,
    parameter int unsigned MAX_GUESSES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enterA,
    input  logic       enterB,
    input  logic [2:0] letterIn,
    output logic [7:0] LEDX,
    output logic [6:0] SSD3,
    output logic [6:0] SSD2,
    output logic [6:0] SSD1,
    output logic [6:0] SSD0
);

    localparam int unsigned CntW   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int unsigned ScoreW = $clog2(WIN_SCORE + 1);
    localparam int unsigned LifeW  = $clog2(MAX_GUESSES + 1);

    localparam logic [6:0] GlyA     = 7'b0001000;
    localparam logic [6:0] GlyC     = 7'b1000110;
    localparam logic [6:0] GlyE     = 7'b0000110;
    localparam logic [6:0] GlyF     = 7'b0001110;
    localparam logic [6:0] GlyH     = 7'b0001001;
    localparam logic [6:0] GlyL     = 7'b1000111;
    localparam logic [6:0] GlyP     = 7'b0001100;
    localparam logic [6:0] GlyU     = 7'b1000001;
    localparam logic [6:0] GlyDash  = 7'b0111111;
    localparam logic [6:0] GlyBlank = 7'b1111111;
    localparam logic [6:0] GlyB     = 7'b0000011;
    localparam logic [6:0] Dig0     = 7'b1000000;
    localparam logic [6:0] Dig1     = 7'b1111001;
    localparam logic [6:0] Dig2     = 7'b0100100;

    typedef enum logic [2:0] {
        StIdle,
        StCode,
        StGuess,
        StShow,
        StRoundEnd,
        StOver
    } state_e;

    state_e state_q, state_d;

    logic              enter_a_q, enter_b_q;
    logic              press_a, press_b, any_press;
    logic              maker_press, breaker_press;
    logic              maker_q;     // 0: player A is codemaker, 1: player B
    logic              winner_q;    // winner of the last round, same encoding
    logic [1:0]        idx_q;
    logic [2:0]        code_q  [4];
    logic [2:0]        guess_q [4];
    logic [LifeW-1:0]  lives_q;
    logic [CntW-1:0]   cnt_q;
    logic [ScoreW-1:0] score_a_q, score_b_q;

    logic [3:0]  exact, partial;
    logic        all_exact, last_life, hold_done, score_max, round_over, round_winner;
    logic [7:0]  led_d;
    logic [6:0]  disp_d [4];
    logic [27:0] score_disp;

    function automatic logic [6:0] letter_glyph(input logic [2:0] l);
        logic [6:0] g;
        case (l)
            3'd0:    g = GlyA;
            3'd1:    g = GlyC;
            3'd2:    g = GlyE;
            3'd3:    g = GlyF;
            3'd4:    g = GlyH;
            3'd5:    g = GlyL;
            3'd6:    g = GlyP;
            default: g = GlyU;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [ScoreW-1:0] s);
        logic [6:0] g;
        if (s == ScoreW'(0))      g = Dig0;
        else if (s == ScoreW'(1)) g = Dig1;
        else if (s == ScoreW'(2)) g = Dig2;
        else                      g = GlyDash;
        return g;
    endfunction

    always_comb begin
        press_a       = enterA & ~enter_a_q;
        press_b       = enterB & ~enter_b_q;
        any_press     = press_a | press_b;
        maker_press   = maker_q ? press_b : press_a;
        breaker_press = maker_q ? press_a : press_b;
    end

    // Feedback is purely combinational on the stored slots so SHOW needs no extra cycle.
    always_comb begin
        exact   = '0;
        partial = '0;
        for (int i = 0; i < 4; i++) begin
            exact[i] = (guess_q[i] == code_q[i]);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!exact[i] && !exact[j] && (guess_q[i] == code_q[j])) begin
                    partial[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        all_exact    = &exact;
        last_life    = (lives_q == LifeW'(1));
        hold_done    = (cnt_q == CntW'(SHOW_CYCLES - 1));
        score_max    = (score_a_q == ScoreW'(WIN_SCORE)) || (score_b_q == ScoreW'(WIN_SCORE));
        round_over   = all_exact || last_life;
        round_winner = all_exact ? ~maker_q : maker_q;
        score_disp   = {GlyA, digit_glyph(score_a_q), GlyB, digit_glyph(score_b_q)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (any_press) state_d = StCode;
            StCode:     if (maker_press && (idx_q == 2'd3)) state_d = StGuess;
            StGuess:    if (breaker_press && (idx_q == 2'd3)) state_d = StShow;
            StShow:     if (hold_done) state_d = round_over ? StRoundEnd : StGuess;
            StRoundEnd: if (hold_done) state_d = score_max ? StOver : StCode;
            StOver:     if (any_press) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enter_a_q <= 1'b0;
            enter_b_q <= 1'b0;
            maker_q   <= 1'b0;
            winner_q  <= 1'b0;
            idx_q     <= '0;
            lives_q   <= '0;
            cnt_q     <= '0;
            score_a_q <= '0;
            score_b_q <= '0;
            for (int k = 0; k < 4; k++) begin
                code_q[k]  <= '0;
                guess_q[k] <= '0;
            end
        end else begin
            enter_a_q <= enterA;
            enter_b_q <= enterB;
            unique case (state_q)
                StIdle: begin
                    if (any_press) begin
                        maker_q <= ~press_a;
                        idx_q   <= '0;
                    end
                end
                StCode: begin
                    if (maker_press) begin
                        code_q[idx_q] <= letterIn;
                        idx_q         <= idx_q + 2'd1;
                        if (idx_q == 2'd3) lives_q <= LifeW'(MAX_GUESSES);
                    end
                end
                StGuess: begin
                    cnt_q <= '0;
                    if (breaker_press) begin
                        guess_q[idx_q] <= letterIn;
                        idx_q          <= idx_q + 2'd1;
                    end
                end
                StShow: begin
                    if (hold_done) begin
                        cnt_q <= '0;
                        if (!all_exact) lives_q <= lives_q - 1'b1;
                        if (round_over) begin
                            winner_q <= round_winner;
                            if (!round_winner && (score_a_q != ScoreW'(WIN_SCORE))) begin
                                score_a_q <= score_a_q + 1'b1;
                            end
                            if (round_winner && (score_b_q != ScoreW'(WIN_SCORE))) begin
                                score_b_q <= score_b_q + 1'b1;
                            end
                        end else begin
                            for (int k = 0; k < 4; k++) guess_q[k] <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRoundEnd: begin
                    if (hold_done) begin
                        cnt_q <= '0;
                        if (!score_max) begin
                            maker_q <= ~maker_q;
                            idx_q   <= '0;
                            for (int k = 0; k < 4; k++) begin
                                code_q[k]  <= '0;
                                guess_q[k] <= '0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StOver: begin
                    if (any_press) begin
                        score_a_q <= '0;
                        score_b_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        for (int k = 0; k < 4; k++) disp_d[k] = GlyBlank;
        unique case (state_q)
            StIdle: begin
                {disp_d[0], disp_d[1], disp_d[2], disp_d[3]} = score_disp;
            end
            StCode: begin
                for (int k = 0; k < 4; k++) begin
                    if (2'(k) < idx_q) disp_d[k] = GlyDash;
                end
            end
            StGuess: begin
                led_d[2:0] = 3'((4'd1 << lives_q) - 4'd1);
                for (int k = 0; k < 4; k++) begin
                    if (2'(k) < idx_q) disp_d[k] = letter_glyph(guess_q[k]);
                end
            end
            StShow: begin
                led_d = {exact, partial};
                for (int k = 0; k < 4; k++) disp_d[k] = letter_glyph(guess_q[k]);
            end
            StRoundEnd: begin
                led_d = 8'hFF;
`ifdef MASTERMIND_REVEAL_CODE_EN
                if (winner_q == maker_q) begin
                    for (int k = 0; k < 4; k++) disp_d[k] = letter_glyph(code_q[k]);
                end else begin
                    {disp_d[0], disp_d[1], disp_d[2], disp_d[3]} = score_disp;
                end
`else
                {disp_d[0], disp_d[1], disp_d[2], disp_d[3]} = score_disp;
`endif
            end
            StOver: begin
                led_d     = 8'hAA;
                disp_d[0] = GlyDash;
                disp_d[1] = (score_a_q == ScoreW'(WIN_SCORE)) ? GlyA : GlyB;
                disp_d[2] = GlyDash;
                disp_d[3] = GlyDash;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LEDX <= '0;
            SSD3 <= GlyA;
            SSD2 <= Dig0;
            SSD1 <= GlyB;
            SSD0 <= Dig0;
        end else begin
            LEDX <= led_d;
            SSD3 <= disp_d[0];
            SSD2 <= disp_d[1];
            SSD1 <= disp_d[2];
            SSD0 <= disp_d[3];
        end
    end

endmodule

// File: tb/tb_mastermind_game.sv
// Directed bench for mastermind_game: full match, partial feedback, held button, mid-round reset.
module tb_mastermind_game;

    localparam logic [6:0] GlyA = 7'b0001000;
    localparam logic [6:0] GlyC = 7'b1000110;
    localparam logic [6:0] GlyE = 7'b0000110;
    localparam logic [6:0] GlyF = 7'b0001110;
    localparam logic [6:0] GlyH = 7'b0001001;
    localparam logic [6:0] GlyL = 7'b1000111;
    localparam logic [6:0] GlyP = 7'b0001100;
    localparam logic [6:0] GlyU = 7'b1000001;
    localparam logic [6:0] GlyD = 7'b0111111;
    localparam logic [6:0] GlyK = 7'b1111111;
    localparam logic [6:0] GlyB = 7'b0000011;
    localparam logic [6:0] Dig0 = 7'b1000000;
    localparam logic [6:0] Dig1 = 7'b1111001;
    localparam logic [6:0] Dig2 = 7'b0100100;

    localparam logic [27:0] Blank4 = {GlyK, GlyK, GlyK, GlyK};
    localparam logic [27:0] Score00 = {GlyA, Dig0, GlyB, Dig0};
    localparam logic [27:0] Score01 = {GlyA, Dig0, GlyB, Dig1};
`ifdef MASTERMIND_REVEAL_CODE_EN
    localparam logic [27:0] ExpRe2 = {GlyH, GlyL, GlyA, GlyU};
`else
    localparam logic [27:0] ExpRe2 = {GlyA, Dig0, GlyB, Dig2};
`endif

    localparam int PA = 0;
    localparam int PB = 1;
    localparam int W  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enterA;
    logic       enterB;
    logic [2:0] letterIn;
    logic [7:0] LEDX;
    logic [6:0] SSD3;
    logic [6:0] SSD2;
    logic [6:0] SSD1;
    logic [6:0] SSD0;

    always #5 clk = ~clk;

    mastermind_game #(
        .SHOW_CYCLES(4),
        .WIN_SCORE  (2),
        .MAX_GUESSES(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enterA  (enterA),
        .enterB  (enterB),
        .letterIn(letterIn),
        .LEDX    (LEDX),
        .SSD3    (SSD3),
        .SSD2    (SSD2),
        .SSD1    (SSD1),
        .SSD0    (SSD0)
    );

    typedef struct {
        int          act;
        int          arg;
        bit          chk;
        logic [7:0]  led;
        logic [27:0] disp;
        logic [95:0] name;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic add(input int act, input int arg, input bit chk, input logic [7:0] led,
                       input logic [27:0] disp, input logic [95:0] name);
        vec_t v;
        v.act  = act;
        v.arg  = arg;
        v.chk  = chk;
        v.led  = led;
        v.disp = disp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input logic [95:0] name, input logic [7:0] led, input logic [27:0] disp);
        compared++;
        if (LEDX !== led) begin
            mismatched++;
            $display("FAIL %0s LEDX got %b want %b", name, LEDX, led);
        end
        compared++;
        if ({SSD3, SSD2, SSD1, SSD0} !== disp) begin
            mismatched++;
            $display("FAIL %0s SSD got %h want %h", name, {SSD3, SSD2, SSD1, SSD0}, disp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle button pulse, then one released cycle; outputs then show the post-press state.
    task automatic press(input bit who_b, input int letter);
        letterIn = 3'(letter);
        if (who_b) enterB = 1'b1;
        else       enterA = 1'b1;
        idle(1);
        enterA = 1'b0;
        enterB = 1'b0;
        idle(1);
    endtask

    initial begin
        rst      = 1'b1;
        enterA   = 1'b0;
        enterB   = 1'b0;
        letterIn = 3'd0;

        // Match 1: A makes C,E,F,P; B cracks it first try.
        add(PA, 0, 1, 8'h00, Blank4, "code_a");
        add(PB, 5, 1, 8'h00, Blank4, "b_ignored");
        add(PA, 1, 1, 8'h00, {GlyD, GlyK, GlyK, GlyK}, "slot0");
        add(PB, 7, 1, 8'h00, {GlyD, GlyK, GlyK, GlyK}, "b_ign_mid");
        add(PA, 2, 1, 8'h00, {GlyD, GlyD, GlyK, GlyK}, "slot1");
        add(PA, 3, 1, 8'h00, {GlyD, GlyD, GlyD, GlyK}, "slot2");
        add(PA, 6, 1, 8'h07, Blank4, "guess_r1");
        add(PA, 0, 1, 8'h07, Blank4, "a_ign_guess");
        add(PB, 1, 1, 8'h07, {GlyC, GlyK, GlyK, GlyK}, "g0");
        add(PB, 2, 1, 8'h07, {GlyC, GlyE, GlyK, GlyK}, "g1");
        add(PB, 3, 1, 8'h07, {GlyC, GlyE, GlyF, GlyK}, "g2");
        add(PB, 6, 1, 8'hF0, {GlyC, GlyE, GlyF, GlyP}, "show_win");
        add(W,  3, 1, 8'hF0, {GlyC, GlyE, GlyF, GlyP}, "show_hold");
        add(W,  1, 1, 8'hFF, Score01, "round_end1");
        add(W,  3, 1, 8'hFF, Score01, "re_hold");
        add(W,  1, 1, 8'h00, Blank4, "code_b");
        // Round 2: B makes H,L,A,U; A misses three times.
        add(PA, 4, 1, 8'h00, Blank4, "a_ign_code");
        add(PB, 4, 1, 8'h00, {GlyD, GlyK, GlyK, GlyK}, "b_slot0");
        add(PB, 5, 0, 8'h00, Blank4, "");
        add(PB, 0, 0, 8'h00, Blank4, "");
        add(PB, 7, 1, 8'h07, Blank4, "guess_r2");
        add(PA, 2, 1, 8'h07, {GlyE, GlyK, GlyK, GlyK}, "a_g0");
        add(PA, 2, 0, 8'h00, Blank4, "");
        add(PA, 2, 0, 8'h00, Blank4, "");
        add(PA, 2, 1, 8'h00, {GlyE, GlyE, GlyE, GlyE}, "show_miss1");
        add(W,  4, 1, 8'h03, Blank4, "lives2");
        for (int k = 0; k < 3; k++) add(PA, 3, 0, 8'h00, Blank4, "");
        add(PA, 3, 1, 8'h00, {GlyF, GlyF, GlyF, GlyF}, "show_miss2");
        add(W,  4, 1, 8'h01, Blank4, "lives1");
        for (int k = 0; k < 3; k++) add(PA, 6, 0, 8'h00, Blank4, "");
        add(PA, 6, 1, 8'h00, {GlyP, GlyP, GlyP, GlyP}, "show_miss3");
        add(W,  4, 1, 8'hFF, ExpRe2, "round_end2");
        add(W,  4, 1, 8'hAA, {GlyD, GlyB, GlyD, GlyD}, "over");
        add(PA, 0, 1, 8'h00, Score00, "idle_clear");
        // Match 2: partial feedback, then B wins a round.
        add(PA, 0, 1, 8'h00, Blank4, "code_m2");
        add(PA, 1, 0, 8'h00, Blank4, "");
        add(PA, 2, 0, 8'h00, Blank4, "");
        add(PA, 3, 0, 8'h00, Blank4, "");
        add(PA, 6, 1, 8'h07, Blank4, "guess_m2");
        add(PB, 2, 0, 8'h00, Blank4, "");
        add(PB, 1, 0, 8'h00, Blank4, "");
        add(PB, 3, 0, 8'h00, Blank4, "");
        add(PB, 0, 1, 8'h43, {GlyE, GlyC, GlyF, GlyA}, "partial");
        add(W,  4, 1, 8'h03, Blank4, "lives_p");
        add(PB, 1, 0, 8'h00, Blank4, "");
        add(PB, 2, 0, 8'h00, Blank4, "");
        add(PB, 3, 0, 8'h00, Blank4, "");
        add(PB, 6, 1, 8'hF0, {GlyC, GlyE, GlyF, GlyP}, "show_win2");
        add(W,  4, 1, 8'hFF, Score01, "round_end3");
        add(W,  4, 1, 8'h00, Blank4, "code_b2");

        idle(3);
        check("reset", 8'h00, Score00);
        rst = 1'b0;

        foreach (vecs[i]) begin
            case (vecs[i].act)
                PA:      press(1'b0, vecs[i].arg);
                PB:      press(1'b1, vecs[i].arg);
                default: idle(vecs[i].arg);
            endcase
            if (vecs[i].chk) check(vecs[i].name, vecs[i].led, vecs[i].disp);
        end

        // Maker B holds the button for five cycles: exactly one letter lands.
        letterIn = 3'd4;
        enterB   = 1'b1;
        idle(5);
        enterB = 1'b0;
        idle(1);
        check("hold_once", 8'h00, {GlyD, GlyK, GlyK, GlyK});
        press(1'b1, 5);
        press(1'b1, 0);
        press(1'b1, 7);
        check("guess_hold", 8'h07, Blank4);
        press(1'b0, 1);
        check("guess_c", 8'h07, {GlyC, GlyK, GlyK, GlyK});

        // Reset in GUESS with scoreB=1: outputs clear at once, state shows cleared scores.
        rst = 1'b1;
        idle(1);
        check("rst_edge", 8'h00, Score00);
        rst = 1'b0;
        idle(1);
        check("rst_score", 8'h00, Score00);
        press(1'b1, 0);
        check("post_rst", 8'h00, Blank4);
        press(1'b1, 2);
        check("post_rst_b", 8'h00, {GlyD, GlyK, GlyK, GlyK});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
